// File: rtl/radiant_scaler.sv
// radiant_scaler
//   Trigger-rate scaler. Counts rising edges on each trigger channel over a
//   programmable gate period. At the end of every gate the running counts
//   are copied into holding registers, which software reads over WISHBONE.
//
// Ports
//   clk_i            sole clock, all logic on its rising edge
//   rst_n_i          synchronous active-low reset
//   wb_cyc_i/stb_i   WISHBONE classic cycle / strobe
//   wb_we_i          write enable
//   wb_adr_i[15:0]   byte address, word index taken from [9:2]
//   wb_dat_i[31:0]   write data
//   wb_sel_i[3:0]    byte enables, honoured on writes
//   wb_dat_o[31:0]   registered read data, zero outside the ack cycle
//   wb_ack_o         one-cycle acknowledge
//   wb_err_o/rty_o   tied low
//   trig_i           trigger levels, already synchronous to clk_i
//
// Register map (word index)
//   0x00 CTRL    bit0 ENABLE, bit1 CLEAR (write-1 pulse, reads 0)
//   0x01 PERIOD  gate length in cycles, 0 stalls gating
//   0x02 STATUS  [15:0] completed-gate count, bit31 ENABLE mirror
//   0x40+k       held counts of channels 2k (low half) and 2k+1 (high half)
module radiant_scaler #(
  parameter int          NUM_SCALERS    = 24,
  parameter int          SCALER_WIDTH   = 16,
  parameter logic [31:0] PERIOD_DEFAULT = 32'd50000000
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [15:0]            wb_adr_i,
  input  logic [31:0]            wb_dat_i,
  input  logic [3:0]             wb_sel_i,
  output logic [31:0]            wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  input  logic [NUM_SCALERS-1:0] trig_i
);

  localparam logic [SCALER_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [7:0]              ADDR_CTRL   = 8'h00;
  localparam logic [7:0]              ADDR_PERIOD = 8'h01;
  localparam logic [7:0]              ADDR_STATUS = 8'h02;

  logic                   ack_reg;
  logic [31:0]            dat_reg;
  logic                   enable_reg;
  logic [31:0]            period_reg;
  logic [31:0]            period_next;
  logic [31:0]            timer_reg;
  logic [15:0]            update_cnt_reg;
  logic [NUM_SCALERS-1:0] trig_d_reg;

  logic [7:0]             word_idx;
  logic                   bus_req;
  logic                   wr_en;
  logic                   ctrl_wr;
  logic                   period_wr;
  logic                   clear_pulse;
  logic                   active;
  logic                   gate_end;
  logic [NUM_SCALERS-1:0] edge_det;
  logic [31:0]            rd_data;
  logic [15:0]            held16 [NUM_SCALERS];
  // The held-register window is 64 words wide; pairs past the last channel read 0.
  logic [31:0]            pair_word [64];
  logic                   unused_adr;

  assign word_idx    = wb_adr_i[9:2];
  assign unused_adr  = ^{wb_adr_i[15:10], wb_adr_i[1:0]};
  assign bus_req     = wb_cyc_i & wb_stb_i & ~ack_reg;
  assign wr_en       = bus_req & wb_we_i;
  assign ctrl_wr     = wr_en & (word_idx == ADDR_CTRL);
  assign period_wr   = wr_en & (word_idx == ADDR_PERIOD);
  assign clear_pulse = ctrl_wr & wb_sel_i[0] & wb_dat_i[1];
  assign active      = enable_reg & (period_reg != 32'd0);
  assign gate_end    = active & (timer_reg == period_reg - 32'd1);
  assign edge_det    = trig_i & ~trig_d_reg;

  assign wb_ack_o = ack_reg;
  assign wb_dat_o = dat_reg;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;

  // Bus handshake: ack one cycle after an unacknowledged strobe; read data
  // is sampled on the same edge, so a read issued on the gate-end cycle
  // still sees the pre-latch held values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ack_reg <= 1'b0;
      dat_reg <= 32'd0;
    end else begin
      ack_reg <= bus_req;
      dat_reg <= (bus_req & ~wb_we_i) ? rd_data : 32'd0;
    end
  end

  always_comb begin
    period_next = period_reg;
    for (int b = 0; b < 4; b++) begin
      if (period_wr && wb_sel_i[b]) begin
        period_next[8*b +: 8] = wb_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      enable_reg <= 1'b0;
      period_reg <= PERIOD_DEFAULT;
      trig_d_reg <= '0;
    end else begin
      if (ctrl_wr && wb_sel_i[0]) begin
        enable_reg <= wb_dat_i[0];
      end
      period_reg <= period_next;
      trig_d_reg <= trig_i;
    end
  end

  // Gate timer. A PERIOD write restarts the timer but a coincident gate end
  // still latches (the latch lives in the channel blocks); CLEAR overrides all.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      timer_reg      <= 32'd0;
      update_cnt_reg <= 16'd0;
    end else if (clear_pulse) begin
      timer_reg      <= 32'd0;
      update_cnt_reg <= 16'd0;
    end else begin
      if (gate_end) begin
        update_cnt_reg <= update_cnt_reg + 16'd1;
      end
      if (period_wr || gate_end) begin
        timer_reg <= 32'd0;
      end else if (active) begin
        timer_reg <= timer_reg + 32'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SCALERS; gi++) begin : g_chan
      logic [SCALER_WIDTH-1:0] cnt_reg;
      logic [SCALER_WIDTH-1:0] held_reg;
      logic [SCALER_WIDTH-1:0] cnt_sat;

      assign cnt_sat    = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
      assign held16[gi] = 16'(held_reg);

      // An edge arriving on the gate-end cycle belongs to the closing gate.
      always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_pulse) begin
          cnt_reg  <= '0;
          held_reg <= '0;
        end else if (gate_end) begin
          held_reg <= edge_det[gi] ? cnt_sat : cnt_reg;
          cnt_reg  <= '0;
        end else if (active && edge_det[gi]) begin
          cnt_reg <= cnt_sat;
        end
      end
    end

    for (genvar gi = 0; gi < 64; gi++) begin : g_pair
      if (2*gi + 1 < NUM_SCALERS) begin : g_full
        assign pair_word[gi] = {held16[2*gi+1], held16[2*gi]};
      end else if (2*gi < NUM_SCALERS) begin : g_half
        assign pair_word[gi] = {16'd0, held16[2*gi]};
      end else begin : g_none
        assign pair_word[gi] = 32'd0;
      end
    end
  endgenerate

  always_comb begin
    rd_data = 32'd0;
    if (word_idx == ADDR_CTRL) begin
      rd_data = {31'd0, enable_reg};
    end else if (word_idx == ADDR_PERIOD) begin
      rd_data = period_reg;
    end else if (word_idx == ADDR_STATUS) begin
      rd_data = {enable_reg, 15'd0, update_cnt_reg};
    end else if (word_idx[7:6] == 2'b01) begin
      rd_data = pair_word[word_idx[5:0]];
    end
  end

endmodule

// File: tb/tb_radiant_scaler.sv
// Testbench for radiant_scaler: register table, gate corner cases and a
// randomized gate checked against an edge-counting reference model.
module tb_radiant_scaler;

  localparam int NCH = 24;
  localparam int SW  = 8;
  localparam int SAT = (1 << SW) - 1;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            wb_cyc_i, wb_stb_i, wb_we_i;
  logic [15:0]     wb_adr_i;
  logic [31:0]     wb_dat_i;
  logic [3:0]      wb_sel_i;
  logic [31:0]     wb_dat_o;
  logic            wb_ack_o, wb_err_o, wb_rty_o;
  logic [NCH-1:0]  trig;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  radiant_scaler #(.NUM_SCALERS(NCH), .SCALER_WIDTH(SW)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .wb_rty_o (wb_rty_o),
    .trig_i   (trig)
  );

  typedef struct {
    bit          we;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
    bit          pulse;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Called on a negedge; returns on the negedge where ack is seen.
  task automatic wb_read(input logic [15:0] adr, input bit pulse, output logic [31:0] data);
    bit got = 0;
    data = 32'd0;
    wb_adr_i = adr; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk_i);
      if (wb_ack_o) begin
        got = 1;
        data = wb_dat_o;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: read 0x%04h got no ack, required ack within 8 cycles", adr);
    end
    if (pulse) begin
      @(negedge clk_i);
      check("ack_one_cycle", {31'd0, wb_ack_o}, 32'd0);
      check("dat_zero_idle", wb_dat_o, 32'd0);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic wb_write(input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bit got = 0;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk_i);
      if (wb_ack_o) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: write 0x%04h got no ack, required ack within 8 cycles", adr);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  // Clear, set PERIOD, enable. Returns in the first active cycle (timer = 0).
  task automatic start_gate(input logic [31:0] period);
    wb_write(16'h0000, 32'h2, 4'h1);
    wb_write(16'h0004, period, 4'hF);
    wb_write(16'h0000, 32'h1, 4'h1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  vec_t        vecs [15];
  logic [31:0] d;
  int          cnt [NCH];
  logic [NCH-1:0] prev, v;
  int          lo, hi;

  initial begin
    vecs[0]  = '{0, 16'h0000, 32'h0,        4'hF, 32'h00000000, 1};
    vecs[1]  = '{0, 16'h0004, 32'h0,        4'hF, 32'h02FAF080, 1};
    vecs[2]  = '{0, 16'h0008, 32'h0,        4'hF, 32'h00000000, 1};
    vecs[3]  = '{1, 16'h0004, 32'h12345678, 4'h5, 32'h0,        0};
    vecs[4]  = '{0, 16'h0004, 32'h0,        4'hF, 32'h0234F078, 0};
    vecs[5]  = '{0, 16'h8004, 32'h0,        4'hF, 32'h0234F078, 0};
    vecs[6]  = '{1, 16'h0000, 32'h3,        4'h1, 32'h0,        0};
    vecs[7]  = '{0, 16'h0000, 32'h0,        4'hF, 32'h00000001, 0};
    vecs[8]  = '{0, 16'h0008, 32'h0,        4'hF, 32'h80000000, 0};
    vecs[9]  = '{1, 16'h0000, 32'h0,        4'h1, 32'h0,        0};
    vecs[10] = '{1, 16'h00FC, 32'hFFFFFFFF, 4'hF, 32'h0,        0};
    vecs[11] = '{0, 16'h00FC, 32'h0,        4'hF, 32'h00000000, 0};
    vecs[12] = '{0, 16'h0130, 32'h0,        4'hF, 32'h00000000, 0};
    vecs[13] = '{1, 16'h0000, 32'h1,        4'h0, 32'h0,        0};
    vecs[14] = '{0, 16'h0003, 32'h0,        4'hF, 32'h00000000, 0};

    // Reset with a strobe pending: no ack, outputs zero.
    rst_n_i = 1'b0; trig = '0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'h0; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
    tick(3);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("err_rty", {30'd0, wb_err_o, wb_rty_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    rst_n_i = 1'b1;
    tick(1);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].we) begin
        wb_write(vecs[i].adr, vecs[i].dat, vecs[i].sel);
      end else begin
        wb_read(vecs[i].adr, vecs[i].pulse, d);
        check($sformatf("table[%0d] rd 0x%04h", i, vecs[i].adr), d, vecs[i].exp);
      end
    end

    // 7 pulses on ch0, 3 on ch23 inside one 100-cycle gate.
    start_gate(32'd100);
    for (int j = 0; j < 100; j++) begin
      trig = '0;
      if (j >= 2 && j <= 14 && (j % 2 == 0)) trig[0] = 1'b1;
      if (j == 20 || j == 30 || j == 40) trig[23] = 1'b1;
      tick(1);
    end
    trig = '0;
    wb_read(16'h0100, 0, d); check("gate_ch0", d, 32'h00000007);
    wb_read(16'h012C, 0, d); check("gate_ch23", d, 32'h00030000);
    wb_read(16'h0008, 0, d); check("gate_status", d, 32'h80000001);

    // Pulse on ch1 exactly on the gate-end cycle (cycle 19 of a 20-cycle gate).
    start_gate(32'd20);
    for (int j = 0; j < 20; j++) begin
      trig = (j == 5 || j == 19) ? 24'h000002 : 24'h0;
      tick(1);
    end
    trig = '0;
    wb_read(16'h0100, 0, d); check("edge_on_gate_end", d, 32'h00020000);
    for (int j = 21; j < 40; j++) begin
      trig = (j == 25) ? 24'h000002 : 24'h0;
      tick(1);
    end
    trig = '0;
    wb_read(16'h0100, 0, d); check("next_gate_from_zero", d, 32'h00010000);
    wb_read(16'h0008, 0, d); check("two_gates_status", d, 32'h80000002);

    // CLEAR written so it is accepted on the gate-end edge.
    start_gate(32'd20);
    for (int j = 0; j < 19; j++) begin
      trig = (j == 3) ? 24'h000001 : 24'h0;
      tick(1);
    end
    trig = '0;
    wb_write(16'h0000, 32'h3, 4'h1);
    wb_read(16'h0100, 0, d); check("clear_vs_gate_held", d, 32'h00000000);
    wb_read(16'h0008, 0, d); check("clear_vs_gate_status", d, 32'h80000000);
    wb_read(16'h0000, 0, d); check("clear_keeps_enable", d, 32'h00000001);

    // ENABLE=0 for 50 cycles mid-gate with pulses on ch2: nothing counted, timer frozen.
    start_gate(32'd20);
    for (int j = 0; j < 8; j++) begin
      trig = (j == 3) ? 24'h000004 : 24'h0;
      tick(1);
    end
    trig = '0;
    wb_write(16'h0000, 32'h0, 4'h1);       // cycle 8 is the last active one
    for (int k = 0; k < 50; k++) begin
      trig = (k % 2 == 1) ? 24'h000004 : 24'h0;
      tick(1);
    end
    trig = '0;
    tick(1);
    wb_write(16'h0000, 32'h1, 4'h1);       // resumes with 9 active cycles done
    for (int j = 0; j < 10; j++) begin
      trig = (j == 2) ? 24'h000004 : 24'h0;
      tick(1);
    end
    trig = '0;
    wb_read(16'h0104, 0, d); check("read_on_gate_end_prelatch", d, 32'h00000000);
    wb_read(16'h0104, 0, d); check("freeze_resume_count", d, 32'h00000002);
    wb_read(16'h0008, 0, d); check("freeze_status", d, 32'h80000001);

    // ch5 toggling every cycle: 280 edges, counter saturates.
    start_gate(32'd600);
    for (int j = 0; j < 560; j++) begin
      trig = (j % 2 == 0) ? 24'h000020 : 24'h0;
      tick(1);
    end
    trig = '0;
    tick(42);
    wb_read(16'h0108, 0, d); check("saturate_ch5", d, 32'h00FF0000);

    // Randomized gates against an edge-counting model.
    for (int r = 0; r < 3; r++) begin
      start_gate(32'd64);
      for (int c = 0; c < NCH; c++) cnt[c] = 0;
      prev = '0;
      for (int j = 0; j < 64; j++) begin
        v = NCH'($urandom & $urandom);
        for (int c = 0; c < NCH; c++) begin
          if (v[c] && !prev[c]) cnt[c]++;
        end
        prev = v;
        trig = v;
        tick(1);
      end
      trig = '0;
      for (int w = 0; w < NCH / 2; w++) begin
        lo = (cnt[2*w]   > SAT) ? SAT : cnt[2*w];
        hi = (cnt[2*w+1] > SAT) ? SAT : cnt[2*w+1];
        wb_read(16'(16'h0100 + 4*w), 0, d);
        check($sformatf("rand%0d word 0x%02h", r, 8'h40 + w), d, 32'((hi << 16) | lo));
      end
      wb_read(16'h0008, 0, d); check($sformatf("rand%0d status", r), d, 32'h80000001);
    end

    // Reset mid-gate restores everything.
    rst_n_i = 1'b0;
    tick(2);
    rst_n_i = 1'b1;
    tick(1);
    wb_read(16'h0008, 0, d); check("rerst_status", d, 32'h00000000);
    wb_read(16'h0004, 0, d); check("rerst_period", d, 32'h02FAF080);
    wb_read(16'h0100, 0, d); check("rerst_held", d, 32'h00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
